// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN pooling datapath.
package cnn_pkg;

    localparam int unsigned PIX_W = 16;

    typedef enum logic {
        eEVEN = 1'b0,
        eODD  = 1'b1
    } state_e;

endpackage

// File: rtl/cnn_pool_linebuf.sv
// Half-row line buffer: holds horizontal maxima of the even row.
// Write is synchronous; read is combinational. Contents are not reset.
module cnn_pool_linebuf #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 16,
    parameter int unsigned AW    = 3
) (
    input  logic          clk_i,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata_c
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/cnn_pool.sv
// 2x2 stride-2 max pooling over a raster-order feature-map stream.
// Optional macro CNN_POOL_RELU_EN clamps negative pooled results to zero.
module cnn_pool
    import cnn_pkg::*;
#(
    parameter int unsigned R_p = 16,
    parameter int unsigned C_p = 16,
    parameter int unsigned W_p = PIX_W
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           valid_i,
    output logic           ready_o,
    input  logic [W_p-1:0] data_i,
    output logic           valid_o,
    input  logic           ready_i,
    output logic [W_p-1:0] data_o,
    output logic           last_o
);

    localparam int unsigned CW    = ($clog2(C_p) > 1) ? $clog2(C_p) : 2;
    localparam int unsigned RW    = ($clog2(R_p) > 0) ? $clog2(R_p) : 1;
    localparam int unsigned AW    = CW - 1;
    localparam int unsigned DEPTH = C_p / 2;

    state_e                 state_q;
    state_e                 state_d;
    logic [CW-1:0]          col_q;
    logic [RW-1:0]          row_q;
    logic signed [W_p-1:0]  pair_q;
    logic signed [W_p-1:0]  hmax_c;
    logic signed [W_p-1:0]  pool_c;
    logic signed [W_p-1:0]  lb_rdata_c;
    logic                   in_xfer_c;
    logic                   out_xfer_c;
    logic                   col_last_c;
    logic                   row_last_c;
    logic                   lb_we_c;
    logic                   load_c;
    logic [AW-1:0]          lb_addr_c;

    // Accept a new pixel whenever the output slot is empty or draining now.
    assign ready_o    = ~valid_o | ready_i;
    assign in_xfer_c  = valid_i & ready_o;
    assign out_xfer_c = valid_o & ready_i;
    assign col_last_c = (col_q == CW'(C_p - 1));
    assign row_last_c = (row_q == RW'(R_p - 1));
    assign lb_addr_c  = col_q[CW-1:1];
    assign lb_we_c    = in_xfer_c & col_q[0] & (state_q == eEVEN);
    assign load_c     = in_xfer_c & col_q[0] & (state_q == eODD);

    assign hmax_c = (pair_q > $signed(data_i)) ? pair_q : $signed(data_i);

    always_comb begin
        pool_c = (hmax_c > lb_rdata_c) ? hmax_c : lb_rdata_c;
`ifdef CNN_POOL_RELU_EN
        if (pool_c[W_p-1]) begin
            pool_c = '0;
        end
`else
`endif
    end

    cnn_pool_linebuf #(
        .DEPTH (DEPTH),
        .W     (W_p),
        .AW    (AW)
    ) u_linebuf (
        .clk_i   (clk_i),
        .we      (lb_we_c),
        .waddr   (lb_addr_c),
        .wdata   (hmax_c),
        .raddr   (lb_addr_c),
        .rdata_c (lb_rdata_c)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= eEVEN;
        end else begin
            state_q <= state_d;
        end
    end

    // Row-parity FSM: flips at the end of every input row.
    always_comb begin
        state_d = state_q;
        if (in_xfer_c && col_last_c) begin
            case (state_q)
                eEVEN:   state_d = eODD;
                eODD:    state_d = eEVEN;
                default: state_d = eEVEN;
            endcase
        end
    end

    // Raster position; wraps straight into the next map.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (in_xfer_c) begin
            if (col_last_c) begin
                col_q <= '0;
                row_q <= row_last_c ? '0 : row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            pair_q  <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
            last_o  <= 1'b0;
        end else begin
            if (in_xfer_c && !col_q[0]) begin
                pair_q <= $signed(data_i);
            end
            if (load_c) begin
                data_o  <= pool_c;
                valid_o <= 1'b1;
                last_o  <= row_last_c & col_last_c;
            end else if (out_xfer_c) begin
                valid_o <= 1'b0;
                last_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cnn_pool.sv
// Directed and randomized checks of cnn_pool against a 2x2 window-max model.
module tb_cnn_pool;

    localparam int unsigned R = 4;
    localparam int unsigned C = 4;
    localparam int unsigned W = 16;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] data_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] data_o;
    logic         last_o;

    int errors   = 0;
    int checks   = 0;
    int stalls   = 0;
    int timeouts = 0;
    bit fin;

    logic signed [W-1:0] stim[$];
    logic signed [W-1:0] exp_d[$];
    logic                exp_l[$];
    logic signed [W-1:0] got_d[$];
    logic                got_l[$];

    cnn_pool #(.R_p(R), .C_p(C), .W_p(W)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .last_o  (last_o)
    );

    always #5 clk_i = ~clk_i;

    // Record every output handshake, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (reset_i && valid_o && ready_i) begin
            got_d.push_back($signed(data_o));
            got_l.push_back(last_o);
        end
    end

    // Reference: each map is tiled into 2x2 windows, emitted in raster order.
    task automatic build_exp();
        int nmaps;
        int base;
        logic signed [W-1:0] m;
        nmaps = stim.size() / (R * C);
        for (int k = 0; k < nmaps; k++) begin
            for (int pr = 0; pr < R / 2; pr++) begin
                for (int pc = 0; pc < C / 2; pc++) begin
                    base = k * R * C + pr * 2 * C + pc * 2;
                    m = stim[base];
                    if (stim[base + 1] > m)     m = stim[base + 1];
                    if (stim[base + C] > m)     m = stim[base + C];
                    if (stim[base + C + 1] > m) m = stim[base + C + 1];
`ifdef CNN_POOL_RELU_EN
                    if (m < 0) m = '0;
`endif
                    exp_d.push_back(m);
                    exp_l.push_back((pr == R / 2 - 1) && (pc == C / 2 - 1));
                end
            end
        end
    endtask

    task automatic send(input logic [W-1:0] px);
        int  guard;
        bit  done;
        guard = 0;
        done  = 1'b0;
        valid_i = 1'b1;
        data_i  = px;
        while (!done && guard < 200) begin
            @(negedge clk_i);
            done = ready_o;
            if (!ready_o) stalls++;
            @(posedge clk_i);
            #1;
            guard++;
        end
        if (!done) timeouts++;
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic check_outputs(input string tag);
        int n;
        checks++;
        assert (got_d.size() === exp_d.size()) else begin
            errors++;
            $error("FAIL %s_count observed=%0d expected=%0d", tag, got_d.size(), exp_d.size());
        end
        n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            assert (got_d[i] === exp_d[i]) else begin
                errors++;
                $error("FAIL %s_data[%0d] observed=%0d expected=%0d", tag, i, got_d[i], exp_d[i]);
            end
            checks++;
            assert (got_l[i] === exp_l[i]) else begin
                errors++;
                $error("FAIL %s_last[%0d] observed=%0b expected=%0b", tag, i, got_l[i], exp_l[i]);
            end
        end
        got_d.delete();
        got_l.delete();
        exp_d.delete();
        exp_l.delete();
        stim.delete();
    endtask

    task automatic load_ramp(input bit neg);
        for (int i = 0; i < R * C; i++) begin
            stim.push_back(neg ? W'(-(i + 1)) : W'(i));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        assert (valid_o === 1'b0) else begin
            errors++;
            $error("FAIL %s_valid observed=%0b expected=0", tag, valid_o);
        end
        checks++;
        assert (last_o === 1'b0) else begin
            errors++;
            $error("FAIL %s_last observed=%0b expected=0", tag, last_o);
        end
        checks++;
        assert (data_o === '0) else begin
            errors++;
            $error("FAIL %s_data observed=%0h expected=0", tag, data_o);
        end
    endtask

    initial begin
        reset_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        data_i  = '0;

        // Reset state
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check_reset_outputs("reset");
        checks++;
        assert (ready_o === 1'b1) else begin
            errors++;
            $error("FAIL reset_ready observed=%0b expected=1", ready_o);
        end
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        idle(2);

        // Ramp
        load_ramp(1'b0);
        build_exp();
        for (int i = 0; i < R * C; i++) send(stim[i]);
        idle(3);
        check_outputs("ramp");

        // All-negative ramp
        load_ramp(1'b1);
        build_exp();
        for (int i = 0; i < R * C; i++) send(stim[i]);
        idle(3);
        check_outputs("neg");

        // Downstream backpressure while an output is pending
        load_ramp(1'b0);
        build_exp();
        for (int i = 0; i < 6; i++) send(stim[i]);
        ready_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            checks++;
            assert (valid_o === 1'b1 && $signed(data_o) === exp_d[0]) else begin
                errors++;
                $error("FAIL hold_data observed=%0b/%0d expected=1/%0d", valid_o, $signed(data_o), exp_d[0]);
            end
            checks++;
            assert (ready_o === 1'b0) else begin
                errors++;
                $error("FAIL hold_ready observed=%0b expected=0", ready_o);
            end
            @(posedge clk_i);
            #1;
        end
        ready_i = 1'b1;
        for (int i = 6; i < R * C; i++) send(stim[i]);
        idle(3);
        check_outputs("backpressure");

        // Reset mid-map discards the partial map
        for (int i = 0; i < 6; i++) send(W'(i));
        idle(1);
        reset_i = 1'b0;
        #3;
        check_reset_outputs("midreset");
        @(posedge clk_i);
        #1;
        reset_i = 1'b1;
        got_d.delete();
        got_l.delete();
        load_ramp(1'b0);
        build_exp();
        for (int i = 0; i < R * C; i++) send(stim[i]);
        idle(3);
        check_outputs("after_reset");

        // Two maps back to back with valid_i held high
        load_ramp(1'b0);
        for (int i = 0; i < R * C; i++) stim.push_back(W'(100 - 3 * i));
        build_exp();
        stalls = 0;
        for (int i = 0; i < 2 * R * C; i++) send(stim[i]);
        idle(3);
        checks++;
        assert (stalls === 0) else begin
            errors++;
            $error("FAIL b2b_ready_stalls observed=%0d expected=0", stalls);
        end
        check_outputs("b2b");

        // valid_i toggling every other cycle
        load_ramp(1'b0);
        build_exp();
        for (int i = 0; i < R * C; i++) begin
            send(stim[i]);
            idle(1);
        end
        idle(3);
        check_outputs("toggle");

        // Random maps with random valid gaps and random ready_i
        for (int i = 0; i < 3 * R * C; i++) stim.push_back(W'($urandom_range(0, 65535)));
        build_exp();
        fin = 1'b0;
        fork
            begin
                for (int i = 0; i < 3 * R * C; i++) begin
                    idle($urandom_range(0, 2));
                    send(stim[i]);
                end
                fin = 1'b1;
            end
            begin
                while (!fin) begin
                    @(posedge clk_i);
                    #1;
                    ready_i = ($urandom_range(0, 9) < 7);
                end
                ready_i = 1'b1;
            end
        join
        idle(4);
        check_outputs("random");

        checks++;
        assert (timeouts === 0) else begin
            errors++;
            $error("FAIL send_timeouts observed=%0d expected=0", timeouts);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
